wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 92 +++++++++
 tb/tb_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-requester round-robin arbiter sharing one register-file write port.
// Grants are combinational; the granted write is registered onto LE/RW/PW.
module wb_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             a_valid,
  input  logic [4:0]       a_rd,
  input  logic [31:0]      a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [4:0]       b_rd,
  input  logic [31:0]      b_data,
  output logic             b_ready,
  output logic             LE,
  output logic [4:0]       RW,
  output logic [31:0]      PW,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic GrantA = 1'b0;
  localparam logic GrantB = 1'b1;

  logic             last_grant_q, last_grant_d;
  logic             le_q, le_d;
  logic [4:0]       rw_q, rw_d;
  logic [31:0]      pw_q, pw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer_a, xfer_b;

  // A wins contention unless it was the most recent grantee.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset && !hold) begin
      if (a_valid && (!b_valid || last_grant_q == GrantB)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  assign xfer_a = a_valid & a_ready;
  assign xfer_b = b_valid & b_ready;

  always_comb begin
    last_grant_d = last_grant_q;
    le_d         = 1'b0;
    rw_d         = rw_q;
    pw_d         = pw_q;
    cnt_d        = cnt_q;
    if (xfer_a) begin
      last_grant_d = GrantA;
      le_d         = |a_rd;
      rw_d         = a_rd;
      pw_d         = a_data;
    end else if (xfer_b) begin
      last_grant_d = GrantB;
      le_d         = |b_rd;
      rw_d         = b_rd;
      pw_d         = b_data;
    end
    if (a_valid && b_valid && !hold && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GrantB;
      le_q         <= 1'b0;
      rw_q         <= '0;
      pw_q         <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      le_q         <= le_d;
      rw_q         <= rw_d;
      pw_q         <= pw_d;
      cnt_q        <= cnt_d;
    end
  end

  assign LE           = le_q;
  assign RW           = rw_q;
  assign PW           = pw_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes queued at grant time and
// compared against LE/RW/PW one edge later; a small register-file model observes commits.
module tb_wb_arbiter;

  typedef struct packed {
    logic        le;
    logic [4:0]  rw;
    logic [31:0] pw;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, a_ready2, b_ready2;
  logic        LE, LE2;
  logic [4:0]  RW, RW2;
  logic [31:0] PW, PW2;
  logic [7:0]  conflict_cnt;
  logic [1:0]  conflict_cnt2;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_cnt  = 0;
  int          exp_cnt2 = 0;
  logic [4:0]  prev_rw  = '0;
  logic [31:0] prev_pw  = '0;
  wr_t         exp_q[$];
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .LE(LE), .RW(RW), .PW(PW), .conflict_cnt(conflict_cnt)
  );

  wb_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready2),
    .LE(LE2), .RW(RW2), .PW(PW2), .conflict_cnt(conflict_cnt2)
  );

  // Register file that commits whatever the arbiter presents.
  always @(posedge clk) begin
    if (LE === 1'b1) rf[RW] <= PW;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check grants, queue the expected write, advance one edge, compare outputs.
  task automatic cyc(input logic ea, input logic eb);
    wr_t w;
    #1;
    chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
    chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
    if (ea) begin
      w.le = (a_rd != 5'd0); w.rw = a_rd; w.pw = a_data; exp_q.push_back(w);
    end else if (eb) begin
      w.le = (b_rd != 5'd0); w.rw = b_rd; w.pw = b_data; exp_q.push_back(w);
    end
    if (a_valid && b_valid && !hold) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("LE", {31'd0, LE}, {31'd0, w.le});
      chk("RW", {27'd0, RW}, {27'd0, w.rw});
      chk("PW", PW, w.pw);
      prev_rw = w.rw;
      prev_pw = w.pw;
    end else begin
      chk("LE idle", {31'd0, LE}, 32'd0);
      chk("RW hold", {27'd0, RW}, {27'd0, prev_rw});
      chk("PW hold", PW, prev_pw);
    end
    chk("conflict_cnt", {24'd0, conflict_cnt}, exp_cnt);
    chk("conflict_cnt sat", {30'd0, conflict_cnt2}, exp_cnt2);
  endtask

  task automatic reset_checks();
    chk("rst LE", {31'd0, LE}, 32'd0);
    chk("rst RW", {27'd0, RW}, 32'd0);
    chk("rst PW", PW, 32'd0);
    chk("rst cnt", {24'd0, conflict_cnt}, 32'd0);
    chk("rst a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst b_ready", {31'd0, b_ready}, 32'd0);
    exp_q.delete();
    prev_rw  = '0;
    prev_pw  = '0;
    exp_cnt  = 0;
    exp_cnt2 = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #1 reset_checks();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; hold = 1'b0;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
    #2 reset_checks();
    a_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Single A request, then idle.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    cyc(1'b1, 1'b0);
    a_valid = 1'b0;
    cyc(1'b0, 1'b0);

    // Write to %g0 from B is consumed but not committed.
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFFFFFF;
    cyc(1'b0, 1'b1);
    b_valid = 1'b0;
    cyc(1'b0, 1'b0);

    // Contention held from reset: A, B, A, B, then B alone.
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h22;
    apply_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    a_valid = 1'b0;
    cyc(1'b0, 1'b1);

    // Hold blocks grants; last grant was B so A resumes first.
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h88;
    hold = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    hold = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);

    // Counter saturation in the narrow instance.
    a_rd = 5'd3; a_data = 32'h33; b_rd = 5'd4; b_data = 32'h44;
    apply_reset();
    repeat (3) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
    end
    chk("sat value", {30'd0, conflict_cnt2}, 32'd3);

    // Reset between accept and commit drops the write.
    a_valid = 1'b0; b_valid = 1'b0;
    cyc(1'b0, 1'b0);
    chk("rf before", rf[5], 32'hDEADBEEF);
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hCAFEF00D;
    #1 chk("mid a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #2 chk("mid LE pre-reset", {31'd0, LE}, 32'd1);
    reset = 1'b1;
    #1 reset_checks();
    a_valid = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk("rf unchanged", rf[5], 32'hDEADBEEF);
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hAA;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
